// File: rtl/mbledhesi_serik.sv
// Bit-serial adder/subtractor. Processes BPC bits per clock, LSB first, through a
// ripple full-adder chain. A full operation takes WIDTH/BPC RUN cycles followed by
// one FIN cycle in which DONE pulses.
//
// Parameters:
//   WIDTH - operand and result width in bits
//   BPC   - bits processed per cycle; WIDTH must be a multiple of BPC, BPC >= 1
// Ports:
//   Clock    - clock, rising edge active
//   Reset    - asynchronous active-high reset
//   START    - request a new operation (accepted in IDLE or FIN only)
//   SUB      - 0: A+B, 1: A-B (sampled with START)
//   A, B     - operands (sampled with START)
//   SUM      - result, modulo 2^WIDTH
//   COUT     - carry out of the MSB (for subtraction, 1 = no borrow)
//   OVERFLOW - two's-complement signed overflow
//   ZERO     - SUM == 0
//   BUSY     - operation in progress
//   DONE     - one-cycle pulse, results valid
module mbledhesi_serik #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned BPC   = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtraction
  logic [WIDTH-1:0] res_q;    // result bits enter from the top
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  // One step of the ripple chain over the lowest BPC unprocessed bits.
  logic [BPC-1:0]       step_sum;
  logic                 step_cout;
  logic                 step_top_cin;  // carry into the top bit of this chunk
  logic [WIDTH+BPC-1:0] res_cat;
  logic [WIDTH-1:0]     res_next;
  logic                 last_step;

  always_comb begin
    logic cy;
    cy           = carry_q;
    step_sum     = '0;
    step_top_cin = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      step_sum[i] = a_q[i] ^ b_q[i] ^ cy;
      if (i == BPC - 1) begin
        step_top_cin = cy;
      end
      cy = (a_q[i] & b_q[i]) | (cy & (a_q[i] ^ b_q[i]));
    end
    step_cout = cy;
  end

  // Shift the new chunk in from the top; after N steps the LSB chunk sits at bit 0.
  assign res_cat   = {step_sum, res_q};
  assign res_next  = res_cat[WIDTH+BPC-1:BPC];
  assign last_step = (cnt_q == CW'(N - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      SUM      <= '0;
      COUT     <= 1'b0;
      OVERFLOW <= 1'b0;
      ZERO     <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        StIdle, StFin: begin
          if (START) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{SUB}};
            carry_q <= SUB;
            cnt_q   <= '0;
            res_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          // START is ignored here; the running operation always completes.
          a_q     <= a_q >> BPC;
          b_q     <= b_q >> BPC;
          carry_q <= step_cout;
          res_q   <= res_next;
          cnt_q   <= cnt_q + CW'(1);
          if (last_step) begin
            // Visible outputs change only here, so no partial sums leak out.
            SUM      <= res_next;
            COUT     <= step_cout;
            OVERFLOW <= step_top_cin ^ step_cout;
            ZERO     <= (res_next == '0);
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            state_q  <= StFin;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbledhesi_serik.sv
// Bench for mbledhesi_serik: a default-parameter instance checked through a
// scoreboard (directed table, mid-run START, reset abort, back-to-back), plus a
// bank of instances with BPC in {1,2,3,4,8,24} compared against an arithmetic model.
module tb_mbledhesi_serik;

  localparam int unsigned W  = 24;
  localparam int unsigned N  = 24;
  localparam int unsigned NI = 6;
  localparam logic [NI*8-1:0] BPC_PACK = {8'd24, 8'd8, 8'd4, 8'd3, 8'd2, 8'd1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic         start, sub;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, zero, busy, done;

  mbledhesi_serik dut (
    .Clock(clk), .Reset(rst), .START(start), .SUB(sub), .A(a), .B(b),
    .SUM(sum), .COUT(cout), .OVERFLOW(ovf), .ZERO(zero), .BUSY(busy), .DONE(done)
  );

  // Instance bank for the BPC sweep
  logic          r_start, r_sub;
  logic [W-1:0]  r_a, r_b;
  logic [W-1:0]  r_sum [NI];
  logic [NI-1:0] r_cout, r_ovf, r_zero, r_busy, r_done;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    mbledhesi_serik #(.WIDTH(W), .BPC(int'(BPC_PACK[g*8 +: 8]))) u_dut (
      .Clock(clk), .Reset(rst), .START(r_start), .SUB(r_sub), .A(r_a), .B(r_b),
      .SUM(r_sum[g]), .COUT(r_cout[g]), .OVERFLOW(r_ovf[g]), .ZERO(r_zero[g]),
      .BUSY(r_busy[g]), .DONE(r_done[g])
    );
  end

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  res_t sb_q[$];
  res_t last_res;
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    logic [W-1:0] yb;
    logic [W:0]   full;
    res_t         r;
    yb     = y ^ {W{s}};
    full   = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, s};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == yb[W-1]) && (r.sum[W-1] != x[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic int bpc_of(input int g);
    return int'(BPC_PACK[g*8 +: 8]);
  endfunction

  // Scoreboard monitor for the main instance; between DONEs the outputs must hold.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      last_res = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    end else if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("overflow", ovf, e.ovf);
        check("zero", zero, e.zero);
        check("busy_in_fin", busy, 0);
        last_res = e;
      end
    end else begin
      check("outputs_hold", {sum, cout, ovf, zero},
            {last_res.sum, last_res.cout, last_res.ovf, last_res.zero});
    end
  end

  // One operation on the main instance, with a stray START pulse at RUN cycle 5.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        input res_t e);
    int edges, busy_cycles;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    edges = 1; busy_cycles = 0; seen = 1'b0;
    #1 start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        start = (busy_cycles == 5);
        if (start) begin
          a = W'($urandom); b = W'($urandom);
        end
        @(posedge clk);
        edges++;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency_edges", edges, N + 1);
    check("busy_cycles", busy_cycles, N);
  endtask

  // One operation on the whole bank, each instance checked at its own DONE.
  task automatic run_rand(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    res_t          e;
    logic [NI-1:0] seen;
    int            edges;
    e = ref_add(ia, ib, isub);
    @(negedge clk);
    r_a = ia; r_b = ib; r_sub = isub; r_start = 1'b1;
    @(posedge clk);
    edges = 1; seen = '0;
    #1 r_start = 1'b0;
    for (int i = 0; i < 40 && seen != {NI{1'b1}}; i++) begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (r_done[g]) begin
          seen[g] = 1'b1;
          check($sformatf("rand_result_bpc%0d", bpc_of(g)),
                {r_sum[g], r_cout[g], r_ovf[g], r_zero[g]}, {e.sum, e.cout, e.ovf, e.zero});
          check($sformatf("rand_latency_bpc%0d", bpc_of(g)), edges, W / bpc_of(g) + 1);
        end
      end
      @(posedge clk);
      edges++;
    end
    check("rand_all_done", seen, {NI{1'b1}});
  endtask

  initial begin
    int   t, t_prev;
    bit   ok;
    res_t e;
    logic [W-1:0] xa [4];
    logic [W-1:0] xb [4];
    logic         xs [4];

    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    r_start = 1'b0; r_sub = 1'b0; r_a = '0; r_b = '0;

    tbl[0] = '{a: 24'h000001, b: 24'h000001, sub: 1'b0, sum: 24'h000002, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[1] = '{a: 24'hFFFFFF, b: 24'h000001, sub: 1'b0, sum: 24'h000000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    tbl[2] = '{a: 24'h7FFFFF, b: 24'h000001, sub: 1'b0, sum: 24'h800000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
    tbl[3] = '{a: 24'h000005, b: 24'h000007, sub: 1'b1, sum: 24'hFFFFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[4] = '{a: 24'h000007, b: 24'h000007, sub: 1'b1, sum: 24'h000000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    tbl[5] = '{a: 24'h800000, b: 24'h000001, sub: 1'b1, sum: 24'h7FFFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
    tbl[6] = '{a: 24'h123456, b: 24'h654321, sub: 1'b0, sum: 24'h777777, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    tbl[7] = '{a: 24'h800000, b: 24'h800000, sub: 1'b0, sum: 24'h000000, cout: 1'b1, ovf: 1'b1, zero: 1'b1};

    // Reset state
    #12;
    check("reset_outputs", {sum, cout, ovf, zero, busy, done}, '0);
    check("reset_bank_busy_done", {r_busy, r_done}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      e = '{sum: tbl[i].sum, cout: tbl[i].cout, ovf: tbl[i].ovf, zero: tbl[i].zero};
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, e);
    end

    // Reset mid-RUN: stray START at cycle 5, reset at cycle 10, no DONE afterwards
    @(negedge clk);
    a = 24'h000001; b = 24'h000002; sub = 1'b0; start = 1'b1;
    sb_q.push_back(ref_add(24'h000001, 24'h000002, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start = 1'b1; a = 24'h0ABCDE; b = 24'h012345;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_before_reset", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    #1 check("reset_async_outputs", {sum, cout, ovf, zero, busy, done}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    e = '{sum: 24'h000007, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    run_op(24'h000003, 24'h000004, 1'b0, e);

    // Back-to-back with START held high, new operands on each FIN
    xa[0] = 24'h111111; xb[0] = 24'h222222; xs[0] = 1'b0;
    xa[1] = 24'h000010; xb[1] = 24'h000020; xs[1] = 1'b1;
    xa[2] = 24'h7FFFF0; xb[2] = 24'h000010; xs[2] = 1'b0;
    xa[3] = 24'hABCDEF; xb[3] = 24'hABCDEF; xs[3] = 1'b1;
    @(negedge clk);
    a = xa[0]; b = xb[0]; sub = xs[0]; start = 1'b1;
    sb_q.push_back(ref_add(xa[0], xb[0], xs[0]));
    t = 0; t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        t++;
        if (done) ok = 1'b1;
      end
      check("b2b_done_seen", ok, 1);
      if (k > 0) check("b2b_spacing", t - t_prev, N + 1);
      t_prev = t;
      if (k < 3) begin
        a = xa[k+1]; b = xb[k+1]; sub = xs[k+1];
        sb_q.push_back(ref_add(xa[k+1], xb[k+1], xs[k+1]));
        @(posedge clk);
        #1 check("b2b_busy_after_fin", {busy, done}, 2'b10);
      end else begin
        start = 1'b0;
      end
    end

    // BPC sweep: directed BPC=4 case, then random pairs against the model
    run_rand(24'h123456, 24'h654321, 1'b0);
    check("bpc4_sum_const", {r_sum[3], r_cout[3]}, {24'h777777, 1'b0});
    for (int i = 0; i < 1000; i++) begin
      run_rand(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
